// File: rtl/am_chan_scheduler_pkg.sv
// Shared types and the round-robin pick helper for the multi-channel AM scheduler.
// Samples are Q1.15, modulated results Q2.30-ish 32-bit, factors unsigned Q8.8.
package am_chan_scheduler_pkg;

   typedef logic signed [15:0] sig_t;
   typedef logic signed [31:0] msig_t;
   typedef logic        [15:0] fac_t;

   localparam fac_t FAC_ONE = 16'd256;
   localparam int   MAX_CH  = 8;

   // Returns the first requesting index at or after ptr, wrapping within nch.
   // The caller decides whether anything was requesting at all.
   function automatic logic [2:0] rr_pick(input logic [MAX_CH-1:0] valid,
                                          input logic [2:0]        ptr,
                                          input int                nch);
      logic [2:0] pick;
      logic       found;
      int         idx;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_CH; i++) begin
         idx = (int'(ptr) + i) % nch;
         if (!found && (i < nch) && valid[3'(idx)]) begin
            pick  = 3'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/am_chan_scheduler_if.sv
// Request and result handshake bundle between the channel sources, the scheduler
// and the downstream consumer.
interface am_chan_scheduler_if
   import am_chan_scheduler_pkg::*;
#(
   parameter int NCH = 4
);
   localparam int CHW = $clog2(NCH);

   logic [NCH-1:0] req_valid;
   logic [NCH-1:0] req_ready;
   sig_t [NCH-1:0] req_carrier;
   sig_t [NCH-1:0] req_signal;
   logic           out_valid;
   logic           out_ready;
   msig_t          out_data;
   logic [CHW-1:0] out_ch;

   modport master (
      output req_valid, req_carrier, req_signal, out_ready,
      input  req_ready, out_valid, out_data, out_ch
   );

   modport slave (
      input  req_valid, req_carrier, req_signal, out_ready,
      output req_ready, out_valid, out_data, out_ch
   );

endinterface

// File: rtl/am_chan_scheduler_pipe.sv
// Two-stage AM modulator (multiply, then offset/output register) with a global
// enable; the tag travels alongside the data so results stay channel-labelled.
module am_mod_pipe
   import am_chan_scheduler_pkg::*;
#(
   parameter int TAGW = 2
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en_i,
   input  logic            valid_i,
   input  sig_t            carrier_i,
   input  sig_t            signal_i,
   input  fac_t            fac_i,
   input  logic [TAGW-1:0] tag_i,
   output logic            valid_o,
   output msig_t           data_o,
   output logic [TAGW-1:0] tag_o,
   output logic            s1Valid_o
);

   msig_t             mulW;
   logic signed [39:0] prodW;
   msig_t             interW;
   msig_t             fullW;

   logic            s1Valid_q;
   msig_t           s1Inter_q;
   sig_t            s1Carrier_q;
   logic [TAGW-1:0] s1Tag_q;
   logic            s2Valid_q;
   msig_t           s2Data_q;
   logic [TAGW-1:0] s2Tag_q;

   // Only bits [39:8] of the scaled product survive, so a 40-bit product is enough;
   // the upper bits of inter wrap away on purpose.
   assign mulW   = (32'(carrier_i) * 32'(signal_i)) <<< 1;
   assign prodW  = 40'(mulW) * 40'($signed({1'b0, fac_i}));
   assign interW = 32'(prodW >>> 8);
   assign fullW  = 32'((33'(s1Inter_q) + (33'(s1Carrier_q) <<< 16)) >>> 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid_q   <= 1'b0;
         s1Inter_q   <= '0;
         s1Carrier_q <= '0;
         s1Tag_q     <= '0;
         s2Valid_q   <= 1'b0;
         s2Data_q    <= '0;
         s2Tag_q     <= '0;
      end else if (en_i) begin
         s1Valid_q   <= valid_i;
         s1Inter_q   <= interW;
         s1Carrier_q <= carrier_i;
         s1Tag_q     <= tag_i;
         s2Valid_q   <= s1Valid_q;
         s2Data_q    <= fullW;
         s2Tag_q     <= s1Tag_q;
      end
   end

   assign valid_o   = s2Valid_q;
   assign data_o    = s2Data_q;
   assign tag_o     = s2Tag_q;
   assign s1Valid_o = s1Valid_q;

endmodule

// File: rtl/am_chan_scheduler.sv
// Round-robin front end sharing one AM modulator pipeline across NCH channels,
// with a per-channel runtime modulation factor and whole-pipe backpressure.
module am_chan_scheduler
   import am_chan_scheduler_pkg::*;
#(
   parameter int   NCH     = 4,
   parameter fac_t FAC_RST = FAC_ONE
)(
   input  logic                   clk,
   input  logic                   rst_n,
   am_chan_scheduler_if.slave     bus,
   input  logic                   cfg_we_i,
   input  logic [$clog2(NCH)-1:0] cfg_ch_i,
   input  fac_t                   cfg_fac_i,
   output logic                   busy_o
);

   localparam int             CHW   = $clog2(NCH);
   localparam logic [CHW:0]   NCH_W = (CHW + 1)'(NCH);

   logic           advanceEn;
   logic           anyValid;
   logic           accept;
   logic           cfgHit;
   logic           s1Valid;
   logic [CHW-1:0] grant;
   logic [CHW-1:0] rrPtr_d;

   logic [CHW-1:0] rrPtr_q;
   logic           armed_q;
   fac_t           fac_q [NCH];
   logic           s0Valid_q;
   sig_t           s0Carrier_q;
   sig_t           s0Signal_q;
   fac_t           s0Fac_q;
   logic [CHW-1:0] s0Ch_q;

   // armed_q keeps req_ready low while reset is asserted and for the first edge after.
   assign advanceEn     = !(bus.out_valid && !bus.out_ready);
   assign anyValid      = |bus.req_valid;
   assign grant         = CHW'(rr_pick(MAX_CH'(bus.req_valid), 3'(rrPtr_q), NCH));
   assign accept        = advanceEn && anyValid && armed_q;
   assign bus.req_ready = accept ? (NCH'(1) << grant) : '0;
   assign cfgHit        = cfg_we_i && ({1'b0, cfg_ch_i} < NCH_W);

   always_comb begin
      rrPtr_d = rrPtr_q;
      if (accept) begin
         rrPtr_d = (grant == CHW'(NCH - 1)) ? '0 : grant + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rrPtr_q <= '0;
         armed_q <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            fac_q[i] <= FAC_RST;
         end
      end else begin
         rrPtr_q <= rrPtr_d;
         armed_q <= 1'b1;
         if (cfgHit) begin
            fac_q[cfg_ch_i] <= cfg_fac_i;
         end
      end
   end

   // The factor is latched with the sample, so a write on the accept edge lands afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0Valid_q   <= 1'b0;
         s0Carrier_q <= '0;
         s0Signal_q  <= '0;
         s0Fac_q     <= '0;
         s0Ch_q      <= '0;
      end else if (advanceEn) begin
         s0Valid_q <= accept;
         if (accept) begin
            s0Carrier_q <= bus.req_carrier[grant];
            s0Signal_q  <= bus.req_signal[grant];
            s0Fac_q     <= fac_q[grant];
            s0Ch_q      <= grant;
         end
      end
   end

   am_mod_pipe #(
      .TAGW (CHW)
   ) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (advanceEn),
      .valid_i   (s0Valid_q),
      .carrier_i (s0Carrier_q),
      .signal_i  (s0Signal_q),
      .fac_i     (s0Fac_q),
      .tag_i     (s0Ch_q),
      .valid_o   (bus.out_valid),
      .data_o    (bus.out_data),
      .tag_o     (bus.out_ch),
      .s1Valid_o (s1Valid)
   );

   assign busy_o = s0Valid_q | s1Valid | bus.out_valid;

endmodule

// File: doc/am_chan_scheduler.md
Name: am_chan_scheduler

Overview:
- Time-multiplexes one pipelined AM modulator datapath across NCH independent channel requesters.
- Per-cycle round-robin arbitration with valid/ready handshakes on both sides.
- Holds a runtime modulation-factor register per channel. This replaces the compile-time fac of the single-channel modulator.
- Sits between the per-channel carrier/baseband sample sources and the downstream demodulator/DAC mux. Results are tagged with the channel id.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- FAC_RST, 16'd256, reset modulation factor for every channel (unsigned Q8.8; 256 = 1.0).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NCH  channel i presents a sample pair
- req_ready  out  NCH  one-hot; channel i pair accepted this cycle when req_valid[i] & req_ready[i]
- req_carrier  in  NCH x sig  per-channel carrier sample (Q1.15)
- req_signal  in  NCH x sig  per-channel baseband sample (Q1.15)
- cfg_we  in  1  factor write strobe
- cfg_ch  in  $clog2(NCH)  channel addressed by the write
- cfg_fac  in  16  new factor (unsigned Q8.8)
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  msig  modulated sample
- out_ch  out  $clog2(NCH)  channel tag of out_data
- busy  out  1  any stage of the pipeline occupied

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_ch=0, req_ready=0, busy=0, rr pointer=0, all fac[i]=FAC_RST, pipeline valid bits cleared. A reset asserted mid-operation discards all in-flight samples.
- Pipeline: S0 accept/register → S1 multiply → S2 output register. Global advance en = !(out_valid & !out_ready).
- Arbitration, when en=1: grant = first i with req_valid[i], searching from rr pointer upward with wrap-around. req_ready = onehot(grant). If no request, req_ready=0. When en=0, req_ready=0.
- req_ready is a registered or combinational function of req_valid, rr and en only. It never depends on the outputs.
- After an accept on channel g, rr=(g+1) mod NCH. No accept leaves rr unchanged.
- Capture at accept: carrier, signal, fac[g] and g.
- S1 (all signed, full width):
  - mul = (carrier*signal)<<<1, 32b.
  - inter = (mul * {1'b0,fac}) >>> 8, 41b.
- S2:
  - full = (signed(inter[31:0]) + (carrier<<<16)) >>> 1, 33b.
  - out_data = full[31:0].
  - inter[31:0] truncation wraps modulo 2^32; no saturation.
- Latency: a sample accepted at edge T gives out_valid=1 at edge T+2 when there is no stall. Throughput is 1 sample per cycle.
- Stall: out_valid & !out_ready freezes S0..S2 and holds out_data/out_ch stable. The freeze lasts until a handshake.
- out_valid drops on handshake unless S1 holds a valid entry.
- Config:
  - fac[cfg_ch] updates on the edge where cfg_we=1.
  - A sample accepted on that same edge uses the old factor.
  - A write to cfg_ch≥NCH is ignored.
  - Config writes are independent of stall.
- Ordering: results leave in acceptance order. There is never reorder, drop or duplication.
- busy = OR of the S1 and S2 valid bits, plus a pending accept.

Decomposition:
- pack_me holds:
  - sig (signed 16), msig (signed 32).
  - New fac_t (unsigned 16, Q8.8) and FAC_ONE=16'd256.
  - Function rr_pick(valid, ptr) returning the granted index.
- Sub-module am_mod_pipe: a 2-stage registered modulator with enable.
  - Inputs: carrier, signal, fac, tag, valid_in, en.
  - Outputs: data, tag, valid_out.
- The scheduler owns the arbiter, the fac register file and the backpressure logic.

Test Plan:
- ch0 only, carrier=16384, signal=16384, fac=256: out_data=805306368, out_ch=0, out_valid exactly 2 cycles after accept.
- Write cfg ch2 fac=128, then ch2 carrier=signal=16384: out_data=671088640. A sample accepted on the write edge still yields 805306368.
- All 4 req_valid held high for 8 cycles: grant order 0,1,2,3,0,1,2,3. Each req_ready is one-hot. Tags on the output match.
- Hold out_ready=0 for 5 cycles with traffic present: out_data/out_ch stable, req_ready=0, no loss. On release, results drain in order.
- Wrap: fac=512, carrier=signal=32767: inter[31:0]=-262140, out_data=(−262140+2147418112)>>>1=1073577986.
- Assert rst_n=0 with 2 samples in flight: outputs 0 immediately (async), fac back to 256, and no stale result appears after release.
